instruction_fetch: RTL and testbench

Instruction fetch stage placed directly upstream of the serial processor. It owns the program counter, issues word reads to a synchronous instruction memory, and buffers returned instructions in a small prefetch FIFO. The processor receives them over a valid/ready handshake instead of a free-running instruction input. A redirect input flushes the buffer and restarts fetching from a new address, which provides the hook for future jump/branch instructions.

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency reads to the
// instruction memory and buffers returned words in a small prefetch FIFO.
module instruction_fetch #(
    parameter int          InstrWidth = 16,
    parameter int          AddrWidth  = 8,
    parameter int          Depth      = 2,
    parameter int unsigned ResetPc    = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_redirect,
    input  logic [AddrWidth-1:0]  i_redirect_pc,
    output logic                  o_mem_read,
    output logic [AddrWidth-1:0]  o_mem_address,
    input  logic [InstrWidth-1:0] i_mem_read_data,
    output logic [InstrWidth-1:0] o_instruction,
    output logic [AddrWidth-1:0]  o_pc,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = $clog2(Depth + 1);

    logic [AddrWidth-1:0]  pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [AddrWidth-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [InstrWidth-1:0] fifo_instr_q [Depth];
    logic [AddrWidth-1:0]  fifo_pc_q    [Depth];

    logic                  pop;
    logic                  push;
    logic [CntWidth:0]     level;

    assign o_valid       = (count_q != '0);
    assign o_instruction = fifo_instr_q[rd_ptr_q];
    assign o_pc          = fifo_pc_q[rd_ptr_q];
    assign o_mem_address = pc_q;

    // A redirect voids both the pop and the response landing in the same cycle.
    assign pop  = o_valid && i_ready && !i_redirect;
    assign push = inflight_q && !i_redirect;

    // Credit check: entries held plus the word still in flight, minus what leaves now.
    assign level = {1'b0, count_q}
                 + {{CntWidth{1'b0}}, inflight_q}
                 - {{CntWidth{1'b0}}, pop};

    assign o_mem_read = !i_reset && i_enable && !i_redirect
                        && (level < (CntWidth + 1)'(Depth));

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (i_redirect) begin
            pc_d     = i_redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntWidth'(1);
                2'b01:   count_d = count_q - CntWidth'(1);
                default: count_d = count_q;
            endcase
            if (o_mem_read) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + AddrWidth'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q          <= AddrWidth'(ResetPc);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the storage is reset on purpose so the head fields read zero while
    // empty; it is only a few flops, unlike a RAM that should stay unreset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < Depth; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= i_mem_read_data;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assert property (@(posedge i_clock) disable iff (i_reset)
        !(push && !pop && (count_q == CntWidth'(Depth))));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// phase, all compared each cycle against a queue-based reference model.
module tb_instruction_fetch;

    localparam int IW       = 16;
    localparam int AW       = 8;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic          clk = 1'b0;
    logic          i_reset, i_enable, i_redirect, i_ready;
    logic [AW-1:0] i_redirect_pc;
    logic [IW-1:0] i_mem_read_data;
    logic          o_mem_read, o_valid;
    logic [AW-1:0] o_mem_address, o_pc;
    logic [IW-1:0] o_instruction;

    always #5 clk = ~clk;

    instruction_fetch #(
        .InstrWidth (IW),
        .AddrWidth  (AW),
        .Depth      (DEPTH),
        .ResetPc    (RESET_PC)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_mem_read      (o_mem_read),
        .o_mem_address   (o_mem_address),
        .i_mem_read_data (i_mem_read_data),
        .o_instruction   (o_instruction),
        .o_pc            (o_pc),
        .o_valid         (o_valid),
        .i_ready         (i_ready)
    );

    logic [IW-1:0] mem [256];

    // Reference model: buffered entries, fetch address, outstanding read.
    entry_t        m_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ipc;
    logic [IW-1:0] m_idata;
    bit            m_inflight;
    logic [AW-1:0] delivered[$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // play the memory by driving the word requested in the finished cycle.
    task automatic tick();
        bit            pop;
        bit            exp_read;
        logic          req;
        logic [AW-1:0] addr;
        int            level;
        @(negedge clk);
        pop      = (m_q.size() > 0) && i_ready;
        level    = m_q.size() + int'(m_inflight) - int'(pop);
        exp_read = !i_reset && i_enable && !i_redirect && (level < DEPTH);
        if (checking) begin
            check("mem_read", 32'(o_mem_read), 32'(exp_read));
            check("mem_addr", 32'(o_mem_address), 32'(m_pc));
            check("valid", 32'(o_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("instr", 32'(o_instruction), 32'(m_q[0].instr));
                check("pc", 32'(o_pc), 32'(m_q[0].pc));
            end
        end
        req  = o_mem_read;
        addr = o_mem_address;
        if (i_reset) begin
            m_q.delete();
            m_pc       = AW'(RESET_PC);
            m_inflight = 1'b0;
        end else if (i_redirect) begin
            m_q.delete();
            m_pc       = i_redirect_pc;
            m_inflight = 1'b0;
        end else begin
            if (pop) begin
                delivered.push_back(m_q[0].pc);
                void'(m_q.pop_front());
            end
            if (m_inflight) m_q.push_back('{instr: m_idata, pc: m_ipc});
            m_inflight = exp_read;
            if (exp_read) begin
                m_ipc   = m_pc;
                m_idata = mem[m_pc];
                m_pc    = m_pc + AW'(1);
            end
        end
        @(posedge clk);
        #1;
        i_mem_read_data = (req === 1'b1) ? mem[addr] : IW'($urandom);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 256; k++) mem[k] = IW'(16'h1000 + k);
        i_reset = 1'b1; i_enable = 1'b0; i_redirect = 1'b0; i_ready = 1'b0;
        i_redirect_pc = '0; i_mem_read_data = '0;
        m_pc = '0; m_ipc = '0; m_idata = '0; m_inflight = 1'b0;

        // Reset state
        tick();
        checking = 1'b1;
        tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_addr", 32'(o_mem_address), 32'(RESET_PC));
        check("rst_instr", 32'(o_instruction), 32'd0);
        check("rst_pc", 32'(o_pc), 32'd0);
        check("rst_read", 32'(o_mem_read), 32'd0);

        // Reset then stream: first read now, valid two cycles later
        i_reset = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
        #1;
        check("first_read", 32'(o_mem_read), 32'd1);
        n = 0;
        while (!o_valid && n < 10) begin tick(); n++; end
        check("first_latency", 32'(n), 32'd2);
        for (int i = 0; i < 8; i++) tick();

        // Back-pressure: issue stops, exactly DEPTH entries held, then drain
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("bp_read", 32'(o_mem_read), 32'd0);
        check("bp_valid", 32'(o_valid), 32'd1);
        delivered.delete();
        i_enable = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_count", 32'(delivered.size()), 32'(DEPTH));
        for (int i = 1; i < delivered.size(); i++)
            check("bp_order", 32'(delivered[i]), 32'(delivered[i-1] + AW'(1)));

        // Enable toggle mid-stream
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        i_enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Redirect with two buffered entries and a read in flight
        i_ready = 1'b0;
        tick();
        i_redirect = 1'b1; i_redirect_pc = 8'h40; i_ready = 1'b1;
        delivered.delete();
        tick();
        i_redirect = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin tick(); n++; end
        check("redir_latency", 32'(n), 32'd3);
        check("redir_pc", 32'(o_pc), 32'h40);
        check("redir_no_old", 32'(delivered.size()), 32'd0);

        // Wrap-around of the PC
        i_redirect = 1'b1; i_redirect_pc = 8'hFE;
        tick();
        i_redirect = 1'b0;
        delivered.delete();
        for (int i = 0; i < 8; i++) tick();
        check("wrap_cnt", 32'(delivered.size() >= 4), 32'd1);
        if (delivered.size() >= 4)
            for (int i = 0; i < 4; i++)
                check("wrap_pc", 32'(delivered[i]), 32'(AW'(8'hFE + i)));

        // Random phase with a scrambled memory image
        for (int k = 0; k < 256; k++) mem[k] = IW'($urandom);
        for (int i = 0; i < 400; i++) begin
            i_enable      = ($urandom_range(0, 9) != 0);
            i_ready       = ($urandom_range(0, 2) != 0);
            i_redirect    = ($urandom_range(0, 24) == 0);
            i_redirect_pc = AW'($urandom);
            i_reset       = ($urandom_range(0, 149) == 0);
            tick();
        end
        i_reset = 1'b0; i_redirect = 1'b0;

        // Reset mid-operation with entries buffered and a read in flight
        i_redirect = 1'b1; i_redirect_pc = 8'h20;
        tick();
        i_redirect = 1'b0; i_enable = 1'b1; i_ready = 1'b0;
        n = 0;
        while (!(m_q.size() == DEPTH - 1 && m_inflight) && n < 20) begin tick(); n++; end
        check("mid_setup", 32'(m_q.size() == DEPTH - 1 && m_inflight), 32'd1);
        i_reset = 1'b1; i_enable = 1'b0;
        tick();
        i_reset = 1'b0; i_ready = 1'b1;
        #1;
        check("mid_valid", 32'(o_valid), 32'd0);
        check("mid_addr", 32'(o_mem_address), 32'(RESET_PC));
        delivered.delete();
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_late", 32'(delivered.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
